led_matrix_pwm: RTL
===================

LED_MATRIX_PWM -- requirements
Module: led_matrix_pwm

Interface
REQ-001 SHALL have parameter ROWS, default 4, number of cathode groups (kled_tri lines), legal range 1..8.
REQ-002 SHALL have parameter COLS, default 4, number of anode lines (aled), legal range 1..8.
REQ-003 SHALL have parameter BRIGHT_W, default 4, per-LED brightness width, legal range 1..8.
REQ-004 SHALL have parameter STEP_CYCLES, default 2, clocks per brightness step, minimum 1.
REQ-005 SHALL have parameter BLANK_CYCLES, default 2, dark clocks at the start of each slot, minimum 0.
REQ-006 SHALL have port clk, input, 1 bit: the single clock for all logic.
REQ-007 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-008 SHALL have port pix_data, input, ROWS*COLS*BRIGHT_W bits: brightness of LED i at bits [i*BRIGHT_W +: BRIGHT_W].
REQ-009 SHALL have port load, input, 1 bit: a high level in any cycle captures pix_data into the shadow frame.
REQ-010 SHALL have port aled, output, COLS bits: anode drive, active-low, one-hot-low when selected.
REQ-011 SHALL have port kled_tri, output, ROWS bits: cathode output-enable, active-high, at most one bit set.
REQ-012 SHALL have port frame_sync, output, 1 bit: one-cycle pulse marking the first output cycle of each frame.

Function
REQ-013 SHALL scan LED index i = r*COLS + c, from 0 to ROWS*COLS-1 and wrapping to 0, one slot per index, lighting at most one LED at a time.
REQ-014 SHALL define the slot length as SLOT = BLANK_CYCLES + (2^BRIGHT_W - 1)*STEP_CYCLES clocks, and the frame length as ROWS*COLS*SLOT clocks.
REQ-015 SHALL use a phase counter p (0..SLOT-1) and an index counter i; p wraps to 0 and i increments (i wraps to 0 after ROWS*COLS-1) in the same cycle.
REQ-016 SHALL register all outputs, so that outputs in cycle t reflect the counter state (i, p) of cycle t-1.
REQ-017 SHALL drive, while p < BLANK_CYCLES: aled all ones and kled_tri all zeros (blanking).
REQ-018 SHALL drive, while p >= BLANK_CYCLES: aled[c] = 0 and all other aled bits = 1, where c = i mod COLS.
REQ-019 SHALL drive, while p >= BLANK_CYCLES: kled_tri = (1 << r) if (p - BLANK_CYCLES) < b*STEP_CYCLES, else 0, where r = i / COLS and b = the active-frame brightness of LED i.
REQ-020 SHALL never light an LED with b = 0, and SHALL light an LED with b = 2^BRIGHT_W - 1 for the whole non-blank part of its slot.
REQ-021 SHALL double-buffer: load writes the shadow register and sets a pending flag; multiple loads within one frame keep only the last one.
REQ-022 SHALL, in the cycle where i = last index and p = SLOT-1 and pending = 1, copy shadow into the active frame and clear pending.
REQ-023 SHALL, when load coincides with the REQ-022 transfer cycle, transfer the old shadow, store the new data, and leave pending = 1, so that the new data applies to the following frame.
REQ-024 SHALL assert frame_sync for exactly one cycle, coincident with the output cycle of (i = 0, p = 0), independent of whether a transfer occurred.
REQ-025 SHALL use counters no wider than ceil(log2(max value + 1)), with no arithmetic overflow for any legal parameter set.

Reset
REQ-026 SHALL set, while rst is high, asynchronously: aled all ones, kled_tri = 0, frame_sync = 0, i = 0, p = 0, active frame all zeros, shadow frame all zeros, pending = 0.
REQ-027 SHALL restart the scan at (i = 0, p = 0) on the first clk edge after rst deasserts; an assertion of rst mid-frame discards any pending load.

Verification (defaults: SLOT = 32, frame = 512 clocks)
REQ-028 SHALL cover: reset release with no load -> aled cycles 1110, 1101, 1011, 0111 over 32-clock slots, kled_tri stays 0, frame_sync pulses every 512 clocks.
REQ-029 SHALL cover: load all LEDs = 15 -> from the next frame, each slot shows 2 blank clocks, then 30 clocks with kled_tri one-hot (LED 5: kled_tri = 0010, aled = 1101).
REQ-030 SHALL cover: LED 0 = 3, others 0 -> kled_tri = 0001 for exactly 6 clocks per 512-clock frame.
REQ-031 SHALL cover: two loads in one frame (values A then B) -> only B is displayed in the next frame; A is never displayed.
REQ-032 SHALL cover: load on the transfer cycle -> the old shadow is displayed for one frame, then the new data is displayed.
REQ-033 SHALL cover: rst pulsed mid-slot with kled_tri lit -> kled_tri = 0 immediately (asynchronously), the display is dark after release, and the pending load is lost.

Source files
------------

// File: rtl/led_matrix_pwm.sv
// Scans a ROWS x COLS LED matrix one LED per slot with per-LED PWM brightness and a double-buffered frame.
// Outputs are registered (one clock after the counter state); no backpressure, load is accepted every cycle.
module led_matrix_pwm #(
  parameter int ROWS         = 4,
  parameter int COLS         = 4,
  parameter int BRIGHT_W     = 4,
  parameter int STEP_CYCLES  = 2,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [ROWS*COLS*BRIGHT_W-1:0]     pix_data,
  input  logic                              load,
  output logic [COLS-1:0]                   aled,
  output logic [ROWS-1:0]                   kled_tri,
  output logic                              frame_sync
);

  localparam int N    = ROWS * COLS;
  localparam int SLOT = BLANK_CYCLES + ((1 << BRIGHT_W) - 1) * STEP_CYCLES;
  localparam int IW   = (N > 1) ? $clog2(N) : 1;
  localparam int PW   = (SLOT > 1) ? $clog2(SLOT) : 1;
  // Compare width must hold b*STEP_CYCLES, which can reach SLOT when there is no blanking.
  localparam int CW   = $clog2(SLOT + 1);

  logic [IW-1:0]                  i_q, i_d;
  logic [PW-1:0]                  p_q, p_d;
  logic [N-1:0][BRIGHT_W-1:0]     act_q, act_d;
  logic [N-1:0][BRIGHT_W-1:0]     shd_q, shd_d;
  logic                           pend_q, pend_d;
  logic [COLS-1:0]                aled_q, aled_d;
  logic [ROWS-1:0]                kled_q, kled_d;
  logic                           fsync_q, fsync_d;

  logic                           last_p, last_i, xfer, on, lit;
  logic [BRIGHT_W-1:0]            b;
  logic [CW-1:0]                  ph;
  logic [IW-1:0]                  row, col;

  always_comb begin
    last_p = (p_q == PW'(SLOT - 1));
    last_i = (i_q == IW'(N - 1));
    xfer   = last_p && last_i && pend_q;

    p_d = last_p ? '0 : p_q + PW'(1);
    i_d = i_q;
    if (last_p) i_d = last_i ? '0 : i_q + IW'(1);

    // A load in the transfer cycle lands in shadow after the old shadow moves, and stays pending.
    act_d  = xfer ? shd_q : act_q;
    shd_d  = shd_q;
    pend_d = pend_q && !xfer;
    if (load) begin
      shd_d  = pix_data;
      pend_d = 1'b1;
    end

    row = IW'(i_q / COLS);
    col = IW'(i_q % COLS);
    b   = act_q[i_q];
    on  = (CW'(p_q) >= CW'(BLANK_CYCLES));
    ph  = CW'(p_q) - CW'(BLANK_CYCLES);
    lit = on && (ph < CW'(b) * CW'(STEP_CYCLES));

    for (int c = 0; c < COLS; c++) aled_d[c] = !(on && (col == IW'(c)));
    for (int r = 0; r < ROWS; r++) kled_d[r] = lit && (row == IW'(r));
    fsync_d = (i_q == '0) && (p_q == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_q     <= '0;
      p_q     <= '0;
      act_q   <= '0;
      shd_q   <= '0;
      pend_q  <= 1'b0;
      aled_q  <= '1;
      kled_q  <= '0;
      fsync_q <= 1'b0;
    end else begin
      i_q     <= i_d;
      p_q     <= p_d;
      act_q   <= act_d;
      shd_q   <= shd_d;
      pend_q  <= pend_d;
      aled_q  <= aled_d;
      kled_q  <= kled_d;
      fsync_q <= fsync_d;
    end
  end

  assign aled       = aled_q;
  assign kled_tri   = kled_q;
  assign frame_sync = fsync_q;

endmodule
